// File: rtl/booth_mult_arbiter.sv
// rtl/booth_mult_arbiter.sv - shared registered multiplier with request arbitration, tag pipe and credit FIFO (MULT_ARB_RR_EN selects round-robin)
module booth_mult_arbiter #(
    parameter int N      = 8,
    parameter int NREQ   = 4,
    parameter int LAT    = 1,
    parameter int FDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*N-1:0]        req_a,
    input  logic [NREQ*N-1:0]        req_b,
    output logic [N-1:0]             mul_a,
    output logic [N-1:0]             mul_b,
    input  logic [2*N-1:0]           mul_p,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [2*N-1:0]           rsp_prod
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = $clog2(FDEPTH);
    localparam int CW  = $clog2(FDEPTH + 1);
    localparam logic [CW-1:0] FDEPTH_C = CW'(FDEPTH);

    // operand registers feeding the multiplier
    logic [N-1:0]             mul_a_q, mul_a_d;
    logic [N-1:0]             mul_b_q, mul_b_d;
    // tag pipe: one stage per clock between handshake and product push
    logic [LAT:0]             tag_v_q, tag_v_d;
    logic [LAT:0][IDW-1:0]    tag_id_q, tag_id_d;
    // outstanding = in-flight tags + FIFO occupancy
    logic [CW-1:0]            out_q, out_d;
    // result FIFO
    logic [PW-1:0]            wr_q, wr_d;
    logic [PW-1:0]            rd_q, rd_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [IDW-1:0]           fifo_id_q [FDEPTH];
    logic [IDW-1:0]           fifo_id_d [FDEPTH];
    logic [2*N-1:0]           fifo_p_q  [FDEPTH];
    logic [2*N-1:0]           fifo_p_d  [FDEPTH];

    logic [NREQ-1:0]          grant;
    logic [IDW-1:0]           win;
    logic                     found;
    logic                     credit;
    logic                     hs;
    logic                     push;
    logic                     pop;
    logic                     head_valid;

`ifdef MULT_ARB_RR_EN
    localparam logic [IDW:0] NREQ_C = (IDW+1)'(NREQ);
    logic [IDW-1:0]           ptr_q, ptr_d;
    logic [IDW:0]             rr_sum;
    logic [IDW-1:0]           rr_idx;
`endif

    // Pick one requester; grant only while a FIFO slot is guaranteed for its result
    always_comb begin
        grant  = '0;
        win    = '0;
        found  = 1'b0;
        credit = rst && (out_q < FDEPTH_C);
`ifdef MULT_ARB_RR_EN
        rr_sum = '0;
        rr_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (rr_sum >= NREQ_C) begin
                rr_sum = rr_sum - NREQ_C;
            end
            rr_idx = rr_sum[IDW-1:0];
            if (!found && req_valid[rr_idx]) begin
                found = 1'b1;
                win   = rr_idx;
            end
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found = 1'b1;
                win   = IDW'(i);
            end
        end
`endif
        if (found && credit) begin
            grant[win] = 1'b1;
        end
        hs = |grant;
    end

    assign req_ready = grant;

    // Operand capture, tag shift and credit accounting
    always_comb begin
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                mul_a_d = req_a[i*N +: N];
                mul_b_d = req_b[i*N +: N];
            end
        end
        tag_v_d     = tag_v_q;
        tag_id_d    = tag_id_q;
        tag_v_d[0]  = hs;
        tag_id_d[0] = win;
        for (int s = 1; s <= LAT; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end
        // a pop only returns credit on the following cycle because out_q is registered
        out_d = out_q;
        if (hs && !pop) begin
            out_d = out_q + CW'(1);
        end else if (!hs && pop) begin
            out_d = out_q - CW'(1);
        end
    end

`ifdef MULT_ARB_RR_EN
    // Pointer sits one past the last winner and moves only on a handshake
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
        end
    end
`endif

    // Show-ahead FIFO next state; push and pop may coincide at any occupancy
    always_comb begin
        head_valid = (cnt_q != '0);
        push       = tag_v_q[LAT];
        pop        = head_valid && rsp_ready;
        fifo_id_d  = fifo_id_q;
        fifo_p_d   = fifo_p_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        if (push) begin
            fifo_id_d[wr_q] = tag_id_q[LAT];
            fifo_p_d[wr_q]  = mul_p;
            wr_d = (wr_q == PW'(FDEPTH - 1)) ? '0 : wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = (rd_q == PW'(FDEPTH - 1)) ? '0 : rd_q + PW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Control state; reset drops everything in flight or buffered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
            out_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
`ifdef MULT_ARB_RR_EN
            ptr_q    <= '0;
`endif
        end else begin
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
            out_q    <= out_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
`ifdef MULT_ARB_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    // FIFO storage needs no reset; stale slots are never visible past cnt_q
    always_ff @(posedge clk) begin
        fifo_id_q <= fifo_id_d;
        fifo_p_q  <= fifo_p_d;
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = head_valid;
    assign rsp_id    = head_valid ? fifo_id_q[rd_q] : '0;
    assign rsp_prod  = head_valid ? fifo_p_q[rd_q]  : '0;

    // Credit limit makes overflow impossible; catch any break of that invariant
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (cnt_q == FDEPTH_C)));

endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Shares one registered radix-8 Booth multiplier among NREQ requesters (e.g. systolic-array PEs that time-multiplex a multiplier). It arbitrates operand requests, registers the winning operands onto the multiplier, tracks the requester ID through the multiplier's fixed latency, and returns tagged products through a credit-protected output FIFO with backpressure.

## Interface
Parameters:
- N, 8, operand width (signed two's complement)
- NREQ, 4, number of requesters (≥2)
- LAT, 1, multiplier latency in clocks from operand change to registered product; must match the attached multiplier
- FDEPTH, 4, result FIFO depth and total credit count (≥ LAT+2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request i has valid operands
- req_ready  out  NREQ  grant; at most one bit high
- req_a  in  NREQ*N  operand A of requester i at [i*N +: N]
- req_b  in  NREQ*N  operand B of requester i at [i*N +: N]
- mul_a  out  N  registered operand A to multiplier
- mul_b  out  N  registered operand B to multiplier
- mul_p  in  2N  multiplier product
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer accepts head
- rsp_id  out  clog2(NREQ)  requester index of head
- rsp_prod  out  2N  signed product of head

## Operation
- Handshake i: req_valid[i] & req_ready[i] at a rising edge. Requester holds req_a/req_b stable while valid until handshake.
- req_ready is combinational from req_valid, arbitration state and credit; it is all-zero when no credit is available.
- Credit: outstanding = in-flight entries + FIFO occupancy. Grant allowed only when outstanding < FDEPTH. A pop in the same cycle does not free credit until the next cycle.
- On handshake: mul_a/mul_b ← winner's operands; {valid=1, id} enters a LAT+1-stage tag shift register. Without handshake, mul_a/mul_b hold their value and a bubble (valid=0) enters.
- Tag pipe output valid: push {id, mul_p} into the FIFO. The FIFO cannot overflow by construction; an overflow attempt is a design error (assertion).
- FIFO is show-ahead: rsp_valid/rsp_id/rsp_prod reflect the head; pop on rsp_valid & rsp_ready. Simultaneous push and pop is legal at any occupancy, including full.
- Product is the full 2N-bit signed result, e.g. -128×-128 = +16384 for N=8.

## Timing
- Reset (async assert, sync deassert by system): req_ready=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_prod=0, tag pipe cleared, FIFO empty, RR pointer=0.
- Reset mid-operation discards all in-flight and buffered results; no response is emitted for them.
- Latency: handshake in cycle t → mul_a/mul_b updated at edge t → product pushed at edge t+1+LAT → rsp_valid high in cycle t+LAT+2 (cycle 3 for LAT=1) if the FIFO was empty.
- Throughput: one issue per cycle while credit remains and rsp_ready=1.
- Responses return in issue order.

## Configuration
- MULT_ARB_RR_EN defined: round-robin. The pointer points one past the last granted index and advances only on handshake. The search wraps from NREQ-1 to 0.
- Undefined: fixed priority. The lowest asserted index wins, and the pointer logic is removed.

## Test plan
- Single requester 0, LAT=1, rsp_ready=1: (-6,4), (7,-2), (-5,-3), (127,127), (-128,-128) back-to-back → rsp_prod -24, -14, 15, 16129, 16384 with rsp_id=0. The first rsp_valid appears 3 cycles after the first handshake, and responses are then contiguous.
- All 4 requesters valid continuously, MULT_ARB_RR_EN defined → grants 0,1,2,3,0,… and each gets 25% over 40 cycles. Without the macro, requester 0 gets every grant.
- rsp_ready=0, FDEPTH=4, all requesters valid → exactly 4 handshakes, then req_ready=0. Raising rsp_ready for 1 cycle pops one entry, and exactly one new handshake follows the next cycle.
- Full FIFO with rsp_ready=1 and req_valid held → one pop per cycle and one issue per cycle sustained, with no loss or duplication (scoreboard by id and order).
- Assert rst=0 with 2 products in flight and 2 buffered → all outputs go to 0 immediately. After release, the first new request (3,-3) returns -9 with no stale responses.
- Requester 2 drops req_valid while others contend → requester 2 is never granted and never appears in rsp_id.
